// File: rtl/noise_blanker_pw.sv
// Pre-/post-blanking noise blanker for interleaved X/Y sample pairs with a
// 2*DLY-word delay line. Define NB_ADAPTIVE_EN for the running-average threshold.
module noise_blanker_pw #(
    parameter int W      = 18,
    parameter int MW     = 8,
    parameter int DLY    = 4,
    parameter int HW     = 4,
    parameter int AVG_SH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  dixy,
    input  logic          iv,
    input  logic          iq,
    input  logic [MW-1:0] limit,
    input  logic [HW-1:0] hold,
    output logic [W-1:0]  doxy,
    output logic          ov,
    output logic          oq,
    output logic          blanking,
    output logic [15:0]   pcount
);

    localparam int DEPTH = 2 * DLY;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(DLY + (1 << HW));

    if (DLY < 1 || AVG_SH < 1 || MW > W - 1) begin : g_param_check
        $error("noise_blanker_pw: needs DLY >= 1, AVG_SH >= 1, MW <= W-1");
    end

    typedef enum logic {IDLE, BLANK} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   fill;
    logic [W-1:0]    dl_d [DEPTH];
    logic            dl_q [DEPTH];
    logic [MW-1:0]   xmag;

    logic [W-1:0]    abs_v;
    logic [MW-1:0]   mag;
    logic [MW-1:0]   pmag;
    logic [MW-1:0]   thr;
    logic            pulse;
    logic            unused_lsbs;

    // NOTE: every variable in an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        abs_v = dixy[W-1] ? (W'(0) - dixy) : dixy;
        // Only -2^(W-1) keeps the top bit after negation; it saturates like any other overflow.
        mag   = abs_v[W-1] ? '1 : abs_v[W-2 -: MW];
        pmag  = (iq && (xmag > mag)) ? xmag : mag;
        pulse = iq && (pmag > thr);
    end

    assign unused_lsbs = ^abs_v[W-2-MW:0];

`ifdef NB_ADAPTIVE_EN
    localparam int AW = MW + AVG_SH;

    logic [AW-1:0]     avg;
    logic [MW-1:0]     avg_int;
    logic [2*MW-1:0]   prod;
    logic signed [AW:0] diff;
    logic signed [AW:0] step;

    always_comb begin
        avg_int = avg[AW-1:AVG_SH];
        prod    = ((2*MW)'(avg_int) * (2*MW)'(limit)) >> 3;
        thr     = (prod > (2*MW)'((1 << MW) - 1)) ? '1 : prod[MW-1:0];
        diff    = $signed({1'b0, pmag, {AVG_SH{1'b0}}}) - $signed({1'b0, avg});
        step    = diff >>> AVG_SH;
    end

    // The average tracks background only: pulse pairs and blanked stretches are excluded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg <= '0;
        end else if (iv && iq && !pulse && state != BLANK) begin
            avg <= AW'($signed({1'b0, avg}) + step);
        end
    end
`else
    always_comb thr = limit;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the delay line is reset so a mid-stream reset never replays stale words.
            for (int i = 0; i < DEPTH; i++) begin
                dl_d[i] <= '0;
                dl_q[i] <= 1'b0;
            end
            fill     <= '0;
            xmag     <= '0;
            state    <= IDLE;
            cnt      <= '0;
            pcount   <= '0;
            doxy     <= '0;
            ov       <= 1'b0;
            oq       <= 1'b0;
            blanking <= 1'b0;
        end else if (iv) begin
            dl_d[0] <= dixy;
            dl_q[0] <= iq;
            for (int i = 1; i < DEPTH; i++) begin
                dl_d[i] <= dl_d[i-1];
                dl_q[i] <= dl_q[i-1];
            end
            if (fill != FW'(DEPTH)) fill <= fill + FW'(1);

            ov       <= (fill == FW'(DEPTH));
            oq       <= dl_q[DEPTH-1];
            doxy     <= (state == BLANK) ? '0 : dl_d[DEPTH-1];
            blanking <= (state == BLANK);

            xmag <= iq ? '0 : mag;

            if (pulse) begin
                cnt   <= CW'(DLY) + CW'(hold);
                state <= BLANK;
                if (state == IDLE && pcount != 16'hFFFF) pcount <= pcount + 16'd1;
            end else if (state == BLANK && dl_q[DEPTH-1]) begin
                if (cnt == CW'(1)) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end else begin
            ov <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noise_blanker_pw.sv
// Scoreboard bench for noise_blanker_pw: the driver queues expected output words,
// a negedge monitor pops and compares whenever ov is high.
module tb_noise_blanker_pw;

    localparam int W   = 18;
    localparam int MW  = 8;
    localparam int DLY = 4;
    localparam int HW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  dixy = '0;
    logic          iv = 1'b0;
    logic          iq = 1'b0;
    logic [MW-1:0] limit = 8'd100;
    logic [HW-1:0] hold = 4'd2;
    logic [W-1:0]  doxy;
    logic          ov;
    logic          oq;
    logic          blanking;
    logic [15:0]   pcount;

    always #5 clk = ~clk;

    noise_blanker_pw #(.W(W), .MW(MW), .DLY(DLY), .HW(HW), .AVG_SH(8)) dut (
        .clk(clk), .rst(rst), .dixy(dixy), .iv(iv), .iq(iq), .limit(limit), .hold(hold),
        .doxy(doxy), .ov(ov), .oq(oq), .blanking(blanking), .pcount(pcount)
    );

    typedef struct packed { logic [W-1:0] d; logic q; int pair; } word_t;
    typedef struct packed { logic [W-1:0] d; logic q; logic b; } exp_t;

    word_t hist[$];
    exp_t  sb[$];
    int    blank_lo = 1;
    int    blank_hi = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    n_out = 0;
    logic  last_iv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) last_iv <= iv;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && ov) begin
            n_out++;
            check("ov_follows_iv", 32'(last_iv), 1);
            check("ov_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_word", {doxy, oq, blanking}, e);
            end
        end
    end

    function automatic logic [W-1:0] qval(input int n, input logic q);
        int v;
        v = 32'h1000 + (n % 256);
        if (q) v = -v;
        return v[W-1:0];
    endfunction

    task automatic send_word(input logic [W-1:0] d, input logic q, input int pair, input bit stall);
        word_t w;
        exp_t  e;
        if (stall) begin
            for (int i = 0; i < 8 && $urandom_range(0, 1) == 1; i++) begin
                iv   = 1'b0;
                dixy = W'($urandom);
                iq   = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        iv   = 1'b1;
        dixy = d;
        iq   = q;
        hist.push_back('{d: d, q: q, pair: pair});
        if (hist.size() > 2 * DLY) begin
            w   = hist.pop_front();
            e.b = (w.pair >= blank_lo && w.pair <= blank_hi);
            e.d = e.b ? '0 : w.d;
            e.q = w.q;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        iv  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hist.delete();
        sb.delete();
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Pulses at pairs p1/p2 (X word, or Y word when on_y); pairs lo..hi must come out zeroed.
    task automatic run_pairs(input string name, input int np, input int p1, input int p2,
                             input bit on_y, input int hld, input int lo, input int hi,
                             input bit stall, input int exp_pc);
        logic [W-1:0] x, y;
        do_reset();
        hold     = HW'(hld);
        limit    = 8'd100;
        blank_lo = lo;
        blank_hi = hi;
        for (int n = 0; n < np; n++) begin
            x = qval(n, 1'b0);
            y = qval(n, 1'b1);
            if (n == p1 || n == p2) begin
                if (on_y) y = 18'h20000;
                else      x = 18'h1FFFF;
            end
            send_word(x, 1'b0, n, stall);
            send_word(y, 1'b1, n, stall);
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_pcount"}, 32'(pcount), 32'(exp_pc));
        check({name, "_drained"}, 32'(sb.size()), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int outs_before;
        repeat (3) @(posedge clk);
        #1;

        run_pairs("quiet",     32, -1, -1, 1'b0, 2, 1, 0,   1'b0, 0);
        run_pairs("pulse_x",   32, 20, -1, 1'b0, 2, 17, 22, 1'b0, 1);
        run_pairs("pulse_y",   32, 20, -1, 1'b1, 2, 17, 22, 1'b0, 1);
        run_pairs("hold0",     32, 20, -1, 1'b0, 0, 17, 20, 1'b0, 1);
        run_pairs("retrigger", 32, 20, 23, 1'b0, 2, 17, 25, 1'b0, 1);
        run_pairs("stall",     32, 20, -1, 1'b0, 2, 17, 22, 1'b1, 1);

        // Reset lands while words are still streaming in.
        iv   = 1'b1;
        dixy = 18'h15555;
        iq   = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check("rst_doxy", 32'(doxy), 0);
        check("rst_ov", 32'(ov), 0);
        check("rst_blanking", 32'(blanking), 0);
        check("rst_pcount", 32'(pcount), 0);
        @(posedge clk); #1;
        iv = 1'b0;
        hist.delete();
        sb.delete();
        blank_lo = 1;
        blank_hi = 0;
        rst = 1'b1;
        @(posedge clk); #1;

        outs_before = n_out;
        for (int k = 1; k <= 9; k++) send_word(W'(k), 1'((k - 1) % 2), -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("fill_one_output", 32'(n_out - outs_before), 1);
        check("fill_drained", 32'(sb.size()), 0);
        check("fill_pcount", 32'(pcount), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
